// File: rtl/multi_channel_accum_if.sv
// Handshake and data bundle for multi_channel_accum: beat input, sum output
// and the requantiser compress return path.
interface multi_channel_accum_if #(
  parameter int NCH   = 3,
  parameter int DW    = 21,
  parameter int OUT_W = 21,
  parameter int CW    = 8
);
  logic                    in_vld;
  logic                    in_rdy;
  logic [NCH*DW-1:0]       dot_flat;
  logic                    sum_vld;
  logic                    sum_rdy;
  logic signed [OUT_W-1:0] sum_all;
  logic                    sum_sat;
  logic                    comp_vld;
  logic [CW-1:0]           compress;
  logic [CW-1:0]           ans_reg;
  logic                    ans_vld;

  modport master (
    output in_vld, dot_flat, sum_rdy, comp_vld, compress,
    input  in_rdy, sum_vld, sum_all, sum_sat, ans_reg, ans_vld
  );

  modport slave (
    input  in_vld, dot_flat, sum_rdy, comp_vld, compress,
    output in_rdy, sum_vld, sum_all, sum_sat, ans_reg, ans_vld
  );
endinterface

// File: rtl/multi_channel_accum.sv
// Accumulates NPASS partial dot products per channel, then emits a saturated
// cross-channel sum; also registers the requantiser's compressed result.
module multi_channel_accum #(
  parameter int NCH   = 3,
  parameter int DW    = 21,
  parameter int NPASS = 3,
  parameter int OUT_W = 21,
  parameter int CW    = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  multi_channel_accum_if.slave   bus
);
  localparam int AW  = DW + $clog2(NPASS + 1);
  localparam int SW  = AW + $clog2(NCH + 1);
  localparam int PCW = $clog2(NPASS + 1);
  localparam int EW  = ((SW > OUT_W) ? SW : OUT_W) + 1;
  localparam logic signed [EW-1:0] MAXV = {{(EW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [EW-1:0] MINV = ~MAXV;

  typedef enum logic [1:0] {IDLE, ACC, SUM, HOLD} state_t;

  state_t                 r_state;
  logic [PCW-1:0]         r_pass_cnt;
  logic signed [AW-1:0]   r_acc [NCH];
  logic signed [OUT_W-1:0] r_sum_all;
  logic                   r_sum_sat;
  logic                   r_sum_vld;
  logic [CW-1:0]          r_ans;
  logic                   r_ans_vld;

  logic                   w_take;
  logic signed [DW-1:0]   w_dot [NCH];
  logic signed [SW-1:0]   w_sum;
  logic signed [EW-1:0]   w_sum_ext;
  logic signed [OUT_W-1:0] w_clip;
  logic                   w_sat;

  assign bus.in_rdy  = (r_state == IDLE) || (r_state == ACC);
  assign w_take      = bus.in_vld && bus.in_rdy;
  assign bus.sum_vld = r_sum_vld;
  assign bus.sum_all = r_sum_all;
  assign bus.sum_sat = r_sum_sat;
  assign bus.ans_reg = r_ans;
  assign bus.ans_vld = r_ans_vld;

  always_comb begin
    for (int unsigned c = 0; c < NCH; c++) begin
      w_dot[c] = bus.dot_flat[c*DW +: DW];
    end
  end

  // SW carries enough headroom that the channel sum cannot wrap; clipping is
  // done at a width covering both SW and OUT_W.
  always_comb begin
    w_sum = '0;
    for (int unsigned c = 0; c < NCH; c++) begin
      w_sum = w_sum + {{(SW-AW){r_acc[c][AW-1]}}, r_acc[c]};
    end
    w_sum_ext = {{(EW-SW){w_sum[SW-1]}}, w_sum};
    w_sat     = 1'b0;
    w_clip    = w_sum_ext[OUT_W-1:0];
    if (w_sum_ext > MAXV) begin
      w_sat  = 1'b1;
      w_clip = MAXV[OUT_W-1:0];
    end else if (w_sum_ext < MINV) begin
      w_sat  = 1'b1;
      w_clip = MINV[OUT_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_pass_cnt <= '0;
      for (int unsigned c = 0; c < NCH; c++) r_acc[c] <= '0;
      r_sum_all  <= '0;
      r_sum_sat  <= 1'b0;
      r_sum_vld  <= 1'b0;
      r_ans      <= '0;
      r_ans_vld  <= 1'b0;
    end else begin
      r_ans_vld <= bus.comp_vld;
      if (bus.comp_vld) r_ans <= bus.compress;

      if (clear) begin
        r_state    <= IDLE;
        r_pass_cnt <= '0;
        for (int unsigned c = 0; c < NCH; c++) r_acc[c] <= '0;
        r_sum_vld  <= 1'b0;
      end else begin
        case (r_state)
          IDLE: if (w_take) begin
            for (int unsigned c = 0; c < NCH; c++) begin
              r_acc[c] <= {{(AW-DW){w_dot[c][DW-1]}}, w_dot[c]};
            end
            if (NPASS == 1) begin
              r_pass_cnt <= '0;
              r_state    <= SUM;
            end else begin
              r_pass_cnt <= PCW'(1);
              r_state    <= ACC;
            end
          end
          ACC: if (w_take) begin
            for (int unsigned c = 0; c < NCH; c++) begin
              r_acc[c] <= r_acc[c] + {{(AW-DW){w_dot[c][DW-1]}}, w_dot[c]};
            end
            if (r_pass_cnt == PCW'(NPASS - 1)) begin
              r_pass_cnt <= '0;
              r_state    <= SUM;
            end else begin
              r_pass_cnt <= r_pass_cnt + PCW'(1);
            end
          end
          SUM: begin
            r_sum_all <= w_clip;
            r_sum_sat <= w_sat;
            r_sum_vld <= 1'b1;
            r_state   <= HOLD;
          end
          HOLD: if (bus.sum_rdy) begin
            r_sum_vld <= 1'b0;
            r_state   <= IDLE;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_multi_channel_accum.sv
// Self-checking bench for multi_channel_accum against a frame-level sum/clip model.
module tb_multi_channel_accum;
  localparam int NCH   = 3;
  localparam int DW    = 21;
  localparam int NPASS = 3;
  localparam int OUT_W = 21;
  localparam int CW    = 8;
  localparam longint OMAX = (64'sd1 <<< (OUT_W - 1)) - 1;
  localparam longint OMIN = -OMAX - 1;

  logic clk = 1'b0;
  logic rst;
  logic clear;
  int   checks   = 0;
  int   failures = 0;
  longint last_sum = 0;
  bit     last_sat = 1'b0;

  always #5 clk = ~clk;

  multi_channel_accum_if #(.NCH(NCH), .DW(DW), .OUT_W(OUT_W), .CW(CW)) bus ();

  multi_channel_accum #(
    .NCH(NCH), .DW(DW), .NPASS(NPASS), .OUT_W(OUT_W), .CW(CW)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .clear(clear),
    .bus  (bus.slave)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NCH*DW-1:0] pack(input longint d[NCH]);
    logic [NCH*DW-1:0] r;
    logic [63:0] t;
    r = '0;
    for (int c = 0; c < NCH; c++) begin
      t = d[c];
      r[c*DW +: DW] = t[DW-1:0];
    end
    return r;
  endfunction

  function automatic longint rand_dot(input bit big);
    logic signed [DW-1:0] r;
    if (big) begin
      r = DW'($urandom);
      return longint'(r);
    end
    return longint'($urandom_range(200, 0)) - 100;
  endfunction

  // One full frame: model = plain sum of every beat value, clipped to OUT_W.
  task automatic run_frame(input string name, input longint b[NPASS][NCH],
                           input int gap_max, input int hold_cycles);
    longint s;
    longint e;
    bit     esat;
    logic signed [OUT_W-1:0] ev;
    longint sev[NCH];
    s = 0;
    for (int p = 0; p < NPASS; p++)
      for (int c = 0; c < NCH; c++) s += b[p][c];
    esat = (s > OMAX) || (s < OMIN);
    e    = (s > OMAX) ? OMAX : ((s < OMIN) ? OMIN : s);
    ev   = e[OUT_W-1:0];
    bus.sum_rdy = (hold_cycles == 0);
    for (int p = 0; p < NPASS; p++) begin
      if (p > 0) begin
        int g;
        g = $urandom_range(gap_max, 0);
        for (int k = 0; k < g; k++) begin
          bus.in_vld = 1'b0;
          bus.dot_flat = $urandom;
          tick();
        end
      end
      bus.in_vld   = 1'b1;
      bus.dot_flat = pack(b[p]);
      checks++;
      if (bus.in_rdy !== 1'b1) begin
        failures++;
        $display("FAIL %s in_rdy beat%0d got=%b exp=1", name, p, bus.in_rdy);
      end
      tick();
    end
    bus.in_vld = 1'b0;
    checks++;
    if (bus.sum_vld !== 1'b0) begin
      failures++;
      $display("FAIL %s sum_vld_early got=%b exp=0", name, bus.sum_vld);
    end
    tick();
    checks += 3;
    if (bus.sum_vld !== 1'b1) begin
      failures++;
      $display("FAIL %s sum_vld got=%b exp=1", name, bus.sum_vld);
    end
    if (bus.sum_all !== ev) begin
      failures++;
      $display("FAIL %s sum_all got=%0d exp=%0d", name, bus.sum_all, ev);
    end
    if (bus.sum_sat !== esat) begin
      failures++;
      $display("FAIL %s sum_sat got=%b exp=%b", name, bus.sum_sat, esat);
    end
    if (hold_cycles > 0) begin
      for (int c = 0; c < NCH; c++) sev[c] = 7;
      bus.in_vld   = 1'b1;
      bus.dot_flat = pack(sev);
      for (int k = 0; k < hold_cycles; k++) begin
        tick();
        checks += 3;
        if (bus.in_rdy !== 1'b0) begin
          failures++;
          $display("FAIL %s hold_in_rdy cyc%0d got=%b exp=0", name, k, bus.in_rdy);
        end
        if (bus.sum_vld !== 1'b1) begin
          failures++;
          $display("FAIL %s hold_sum_vld cyc%0d got=%b exp=1", name, k, bus.sum_vld);
        end
        if (bus.sum_all !== ev) begin
          failures++;
          $display("FAIL %s hold_sum_all cyc%0d got=%0d exp=%0d", name, k, bus.sum_all, ev);
        end
      end
      bus.sum_rdy = 1'b1;
    end
    tick();
    bus.in_vld = 1'b0;
    checks += 3;
    if (bus.sum_vld !== 1'b0) begin
      failures++;
      $display("FAIL %s sum_vld_after got=%b exp=0", name, bus.sum_vld);
    end
    if (bus.in_rdy !== 1'b1) begin
      failures++;
      $display("FAIL %s in_rdy_after got=%b exp=1", name, bus.in_rdy);
    end
    if (bus.sum_all !== ev) begin
      failures++;
      $display("FAIL %s sum_all_after got=%0d exp=%0d", name, bus.sum_all, ev);
    end
    last_sum = e;
    last_sat = esat;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear = 1'b0;
    bus.in_vld = 1'b0; bus.sum_rdy = 1'b1; bus.comp_vld = 1'b0;
    bus.compress = '0; bus.dot_flat = '0;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 12; k++) begin
      bus.in_vld   = 1'($urandom);
      bus.dot_flat = {$urandom, $urandom};
      bus.sum_rdy  = 1'($urandom);
      bus.comp_vld = 1'b1;
      bus.compress = CW'($urandom_range(255, 1));
      tick();
    end
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      bus.in_vld   = 1'($urandom);
      bus.dot_flat = {$urandom, $urandom};
      bus.comp_vld = 1'($urandom);
      bus.compress = CW'($urandom);
      tick();
    end
    bus.in_vld = 1'b0; bus.comp_vld = 1'b0; bus.sum_rdy = 1'b1;
    checks += 6;
    if (bus.sum_all !== '0) begin failures++; $display("FAIL reset sum_all got=%0d exp=0", bus.sum_all); end
    if (bus.sum_sat !== 1'b0) begin failures++; $display("FAIL reset sum_sat got=%b exp=0", bus.sum_sat); end
    if (bus.sum_vld !== 1'b0) begin failures++; $display("FAIL reset sum_vld got=%b exp=0", bus.sum_vld); end
    if (bus.ans_reg !== '0) begin failures++; $display("FAIL reset ans_reg got=%h exp=00", bus.ans_reg); end
    if (bus.ans_vld !== 1'b0) begin failures++; $display("FAIL reset ans_vld got=%b exp=0", bus.ans_vld); end
    if (bus.in_rdy !== 1'b1) begin failures++; $display("FAIL reset in_rdy got=%b exp=1", bus.in_rdy); end
    rst = 1'b0;
    last_sum = 0;
    last_sat = 1'b0;
  endtask

  task automatic test_basic();
    longint b[NPASS][NCH];
    b = '{'{10, 20, 30}, '{1, 2, 3}, '{-5, -5, -5}};
    run_frame("basic", b, 0, 0);
  endtask

  task automatic test_saturation();
    longint b[NPASS][NCH];
    b = '{'{1048575, 1048575, 1048575}, '{1048575, 1048575, 1048575}, '{1048575, 1048575, 1048575}};
    run_frame("sat_pos", b, 0, 0);
    b = '{'{-1048576, -1048576, -1048576}, '{-1048576, -1048576, -1048576}, '{-1048576, -1048576, -1048576}};
    run_frame("sat_neg", b, 0, 0);
  endtask

  task automatic test_back_to_back();
    longint b[NPASS][NCH];
    for (int p = 0; p < NPASS; p++)
      for (int c = 0; c < NCH; c++) b[p][c] = rand_dot(1'b0);
    run_frame("backpressure", b, 0, 5);
    b = '{'{7, 7, 7}, '{1, 1, 1}, '{2, 2, 2}};
    run_frame("after_hold", b, 0, 0);
  endtask

  task automatic test_clear();
    longint d[NCH];
    longint b[NPASS][NCH];
    logic signed [OUT_W-1:0] ls;
    ls = last_sum[OUT_W-1:0];
    for (int c = 0; c < NCH; c++) d[c] = 100;
    bus.sum_rdy = 1'b1;
    for (int p = 0; p < 2; p++) begin
      bus.in_vld = 1'b1;
      bus.dot_flat = pack(d);
      tick();
    end
    for (int c = 0; c < NCH; c++) d[c] = 50;
    clear = 1'b1;
    bus.dot_flat = pack(d);
    tick();
    clear = 1'b0;
    bus.in_vld = 1'b0;
    checks += 4;
    if (bus.sum_vld !== 1'b0) begin failures++; $display("FAIL clear sum_vld got=%b exp=0", bus.sum_vld); end
    if (bus.in_rdy !== 1'b1) begin failures++; $display("FAIL clear in_rdy got=%b exp=1", bus.in_rdy); end
    if (bus.sum_all !== ls) begin failures++; $display("FAIL clear sum_all_kept got=%0d exp=%0d", bus.sum_all, ls); end
    if (bus.sum_sat !== last_sat) begin failures++; $display("FAIL clear sum_sat_kept got=%b exp=%b", bus.sum_sat, last_sat); end
    b = '{'{1, 1, 1}, '{1, 1, 1}, '{1, 1, 1}};
    run_frame("after_clear", b, 0, 0);
  endtask

  task automatic test_compress();
    bus.comp_vld = 1'b1;
    bus.compress = 8'hA5;
    tick();
    bus.comp_vld = 1'b0;
    bus.compress = 8'h00;
    checks += 2;
    if (bus.ans_reg !== 8'hA5) begin failures++; $display("FAIL comp ans_reg got=%h exp=a5", bus.ans_reg); end
    if (bus.ans_vld !== 1'b1) begin failures++; $display("FAIL comp ans_vld got=%b exp=1", bus.ans_vld); end
    tick();
    checks += 2;
    if (bus.ans_vld !== 1'b0) begin failures++; $display("FAIL comp ans_vld_pulse got=%b exp=0", bus.ans_vld); end
    if (bus.ans_reg !== 8'hA5) begin failures++; $display("FAIL comp ans_reg_hold got=%h exp=a5", bus.ans_reg); end
    clear = 1'b1;
    bus.comp_vld = 1'b1;
    bus.compress = 8'h3C;
    tick();
    clear = 1'b0;
    bus.comp_vld = 1'b0;
    checks += 2;
    if (bus.ans_reg !== 8'h3C) begin failures++; $display("FAIL comp_clear ans_reg got=%h exp=3c", bus.ans_reg); end
    if (bus.ans_vld !== 1'b1) begin failures++; $display("FAIL comp_clear ans_vld got=%b exp=1", bus.ans_vld); end
  endtask

  task automatic test_rst_in_hold();
    longint d[NCH];
    for (int c = 0; c < NCH; c++) d[c] = 3;
    bus.sum_rdy = 1'b0;
    for (int p = 0; p < NPASS; p++) begin
      bus.in_vld = 1'b1;
      bus.dot_flat = pack(d);
      tick();
    end
    bus.in_vld = 1'b0;
    tick();
    checks++;
    if (bus.sum_vld !== 1'b1) begin failures++; $display("FAIL rst_hold pre_sum_vld got=%b exp=1", bus.sum_vld); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.sum_rdy = 1'b1;
    checks += 5;
    if (bus.sum_vld !== 1'b0) begin failures++; $display("FAIL rst_hold sum_vld got=%b exp=0", bus.sum_vld); end
    if (bus.sum_all !== '0) begin failures++; $display("FAIL rst_hold sum_all got=%0d exp=0", bus.sum_all); end
    if (bus.ans_reg !== '0) begin failures++; $display("FAIL rst_hold ans_reg got=%h exp=00", bus.ans_reg); end
    if (bus.in_rdy !== 1'b1) begin failures++; $display("FAIL rst_hold in_rdy got=%b exp=1", bus.in_rdy); end
    if (bus.sum_sat !== 1'b0) begin failures++; $display("FAIL rst_hold sum_sat got=%b exp=0", bus.sum_sat); end
    last_sum = 0;
    last_sat = 1'b0;
  endtask

  task automatic test_random();
    longint b[NPASS][NCH];
    bit big;
    for (int f = 0; f < 25; f++) begin
      big = 1'($urandom);
      for (int p = 0; p < NPASS; p++)
        for (int c = 0; c < NCH; c++) b[p][c] = rand_dot(big);
      run_frame($sformatf("rand%0d", f), b, 2, $urandom_range(3, 0));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_back_to_back();
    test_clear();
    test_compress();
    test_random();
    test_rst_in_hold();
    test_basic();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/multi_channel_accum.md
Name: multi_channel_accum

Overview:
- Parametrised successor of the three-channel dot-product combiner in the calc path.
- Accumulates NPASS partial dot products for each of NCH channels and forms a saturated cross-channel sum.
- A self-contained pass counter and valid/ready handshakes replace externally decoded cnt values.
- Also holds a registered copy of the compressed result returned by the downstream requantiser.

Parameters:
- NCH, 3: number of channels (>=1).
- DW, 21: signed width of each partial dot product.
- NPASS, 3: partial beats accumulated per frame (>=1).
- OUT_W, 21: signed width of sum_all, saturated.
- CW, 8: width of compress / ans_reg.
- Derived, not overridable:
  - AW = DW + clog2(NPASS+1): per-channel accumulator width.
  - SW = AW + clog2(NCH+1): internal sum width.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-high
- clear  in  1  synchronous frame abort
- in_vld  in  1  dot beat valid
- in_rdy  out  1  block accepts a beat
- dot_flat  in  NCH*DW  channel c in bits [c*DW +: DW], signed
- sum_vld  out  1  sum_all valid
- sum_rdy  in  1  consumer takes sum
- sum_all  out  OUT_W  saturated signed channel sum
- sum_sat  out  1  sum_all was clipped this frame
- comp_vld  in  1  compress valid
- compress  in  CW  compressed result from requantiser
- ans_reg  out  CW  registered compressed result
- ans_vld  out  1  one-cycle pulse when ans_reg updates

Behaviour:
- Reset: rst=1 at a clock edge gives the following on the next cycle:
  - State IDLE, pass_cnt 0, all accumulators 0.
  - sum_all 0, sum_sat 0, sum_vld 0, ans_reg 0, ans_vld 0.
  - in_rdy=1 after reset.
- Priority: rst > clear > normal operation.
- States: IDLE, ACC, SUM, HOLD. Beat accepted = in_vld & in_rdy; in_rdy=1 only in IDLE and ACC.
- IDLE:
  - On accepted beat: acc[c] <= sign-extended dot[c] (overwrite, no add); pass_cnt <= 1.
  - Next state is SUM if NPASS==1, else ACC.
- ACC:
  - On accepted beat: acc[c] <= acc[c] + dot[c].
  - If pass_cnt==NPASS-1: go to SUM and set pass_cnt <= 0; else pass_cnt++.
  - No beat: hold state and values.
- SUM (one cycle, in_rdy=0):
  - s = sum of acc[c] at SW bits, with no internal overflow.
  - sum_all <= clip(s) to [-2^(OUT_W-1), 2^(OUT_W-1)-1]; sum_sat <= (s outside that range).
  - Next state HOLD.
- HOLD:
  - sum_vld=1; sum_all and sum_sat stable; in_rdy=0, so beats presented here are not consumed.
  - On sum_rdy: go to IDLE with sum_vld=0 the next cycle.
  - sum_all keeps its last value after the handshake; sum_sat stays until the next SUM.
- Latency: sum_vld rises 2 cycles after the edge that accepts the last beat.
  - Throughput: one frame per NPASS+2 cycles when sum_rdy is held high.
- clear: in any state, go to IDLE with pass_cnt 0, acc 0 and sum_vld 0. sum_all and sum_sat are not changed. A beat presented in the same cycle as clear is dropped.
- Compress path, independent of the state machine:
  - comp_vld=1: ans_reg <= compress, ans_vld=1 for the next cycle only.
  - Otherwise ans_reg holds and ans_vld=0.
  - clear does not affect this path; rst does.
- Accumulators cannot overflow: AW has headroom for NPASS full-scale beats.
- All outputs are registered except in_rdy, which is decoded from the state.

Test Plan:
- Reset: rst held 2 cycles during random traffic -> every output 0, in_rdy=1, state IDLE.
- Basic frame (NCH=3, NPASS=3, sum_rdy=1): beats (10,20,30), (1,2,3), (-5,-5,-5) -> acc (6,17,28), sum_all=51, sum_sat=0, sum_vld high exactly 2 cycles after 3rd beat, for one cycle.
- Saturation:
  - All dots 1048575 for 3 beats -> s=9437175, sum_all=1048575, sum_sat=1.
  - All dots -1048576 -> sum_all=-1048576, sum_sat=1.
- Backpressure: sum_rdy=0 for 5 cycles in HOLD while in_vld=1 with (7,7,7) -> in_rdy=0 and sum_all stable throughout. After sum_rdy=1, the next frame's first beat is accepted in IDLE and overwrites acc.
- Clear mid-frame: after 2 beats of (100,100,100), pulse clear, then 3 beats of (1,1,1) -> sum_all=9. A beat presented during the clear cycle is dropped.
- Compress path:
  - comp_vld pulse with 0xA5 -> ans_reg=0xA5 and a one-cycle ans_vld pulse on the next cycle.
  - comp_vld with 0x3C asserted during a clear cycle -> ans_reg=0x3C.
  - rst asserted in HOLD -> all zero next cycle.
